// File: rtl/hazard_stall_unit_pkg.sv
// Shared definitions for the hazard/stall controller: the per-cycle pipeline
// action and the hard-wired zero register.
package hazard_stall_unit_pkg;

    // One action per cycle, listed from lowest to highest priority.
    typedef enum logic [1:0] {
        ACT_RUN    = 2'd0,
        ACT_BUBBLE = 2'd1,
        ACT_FLUSH  = 2'd2,
        ACT_FREEZE = 2'd3
    } action_e;

    // Writes to r0 are discarded, so a load to r0 never creates a dependency.
    localparam int REG_ZERO = 0;

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module hazard_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use hazard scoreboard and pipeline enable/flush/freeze controller with
// saturating bubble and freeze counters.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int REG_W    = 5,
    parameter int NUM_SRC  = 2,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     idex_mem_read,
    input  logic [REG_W-1:0]         idex_rd,
    input  logic [NUM_SRC*REG_W-1:0] ifid_src,
    input  logic [NUM_SRC-1:0]       ifid_src_used,
    input  logic                     dmem_busy,
    input  logic                     branch_flush,
    input  logic                     cnt_clr,
    output logic                     pc_we,
    output logic                     ifid_we,
    output logic                     ifid_flush,
    output logic                     idex_flush,
    output logic                     pipe_freeze,
    output logic                     load_use_stall,
    output logic [CNT_W-1:0]         bubble_cnt,
    output logic [CNT_W-1:0]         freeze_cnt
);

    function automatic logic srcMatch(
        input logic [REG_W-1:0]         rd,
        input logic [NUM_SRC*REG_W-1:0] srcs,
        input logic [NUM_SRC-1:0]       used
    );
        logic hit;
        hit = 1'b0;
        if (rd != REG_W'(REG_ZERO)) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (used[i] && (srcs[i*REG_W +: REG_W] == rd)) begin
                    hit = 1'b1;
                end
            end
        end
        return hit;
    endfunction

    logic    hitEx;
    logic    hitSb;
    logic    hazard;
    action_e action;

    // The load currently in EX acts as the unregistered scoreboard head.
    assign hitEx  = idex_mem_read && srcMatch(idex_rd, ifid_src, ifid_src_used);
    assign hazard = hitEx || hitSb;

    if (LOAD_LAT > 1) begin : gSb
        localparam int DEPTH = LOAD_LAT - 1;

        // Element k holds the load that left EX k+1 advancing edges ago.
        logic [DEPTH-1:0] sbValid;
        logic [REG_W-1:0] sbRd [DEPTH];
        logic [DEPTH-1:0] sbHit;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sbValid <= '0;
            end else if (!pipe_freeze) begin
                sbValid[0] <= idex_mem_read;
                for (int k = 1; k < DEPTH; k++) begin
                    sbValid[k] <= sbValid[k-1];
                end
            end
        end

        // NOTE: rd is only meaningful while its valid bit is set, so the
        // address storage carries no reset and stays a plain shift register.
        always_ff @(posedge clk) begin
            if (!pipe_freeze) begin
                sbRd[0] <= idex_rd;
                for (int k = 1; k < DEPTH; k++) begin
                    sbRd[k] <= sbRd[k-1];
                end
            end
        end

        always_comb begin
            sbHit = '0;
            for (int k = 0; k < DEPTH; k++) begin
                sbHit[k] = sbValid[k] && srcMatch(sbRd[k], ifid_src, ifid_src_used);
            end
        end

        assign hitSb = |sbHit;
    end else begin : gNoSb
        assign hitSb = 1'b0;
    end

    // A stalled memory freezes everything; a taken branch kills the ID
    // instruction, so its hazard is irrelevant.
    always_comb begin
        action = ACT_RUN;
        if (dmem_busy) begin
            action = ACT_FREEZE;
        end else if (branch_flush) begin
            action = ACT_FLUSH;
        end else if (hazard) begin
            action = ACT_BUBBLE;
        end
    end

    // NOTE: every output gets a default before the case so no latch can form.
    always_comb begin
        pc_we          = 1'b1;
        ifid_we        = 1'b1;
        ifid_flush     = 1'b0;
        idex_flush     = 1'b0;
        pipe_freeze    = 1'b0;
        load_use_stall = 1'b0;
        if (!rst_n) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else begin
            unique case (action)
                ACT_FREEZE: begin
                    pc_we       = 1'b0;
                    ifid_we     = 1'b0;
                    pipe_freeze = 1'b1;
                end
                ACT_FLUSH: begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end
                ACT_BUBBLE: begin
                    pc_we          = 1'b0;
                    ifid_we        = 1'b0;
                    idex_flush     = 1'b1;
                    load_use_stall = 1'b1;
                end
                ACT_RUN: begin
                    pc_we   = 1'b1;
                    ifid_we = 1'b1;
                end
            endcase
        end
    end

    hazard_sat_counter #(
        .CNT_W(CNT_W)
    ) uBubbleCnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (load_use_stall),
        .clr  (cnt_clr),
        .count(bubble_cnt)
    );

    hazard_sat_counter #(
        .CNT_W(CNT_W)
    ) uFreezeCnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (pipe_freeze),
        .clr  (cnt_clr),
        .count(freeze_cnt)
    );

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Parametrised hazard and stall controller for the pipelined MIPS core, one generation beyond the single-cycle load-use detector. It tracks in-flight loads across a configurable load-to-use latency with an internal scoreboard. It compares up to NUM_SRC source operands of the instruction in ID against that scoreboard, freezes the whole pipeline while data memory is busy, and gives branch flush priority. Saturating performance counters record bubble and freeze cycles. It sits beside the IF/ID and ID/EX pipeline registers and drives PC, IF/ID and downstream register enables.

## Interface
- REG_W, 5, register-address width
- NUM_SRC, 2, source operands compared per ID instruction
- LOAD_LAT, 1, stages after EX before a load result is forwardable (1..4); bubbles inserted for an immediately dependent instruction
- CNT_W, 16, width of each performance counter
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- idex_mem_read  in  1  instruction in EX is a load
- idex_rd  in  REG_W  destination of instruction in EX
- ifid_src  in  NUM_SRC*REG_W  source addresses of instruction in ID; operand i at [i*REG_W +: REG_W]
- ifid_src_used  in  NUM_SRC  per-operand actually-read flag
- dmem_busy  in  1  data memory not completing this cycle
- branch_flush  in  1  taken branch/jump resolved in EX
- cnt_clr  in  1  synchronous clear of both counters
- pc_we  out  1  PC write enable
- ifid_we  out  1  IF/ID write enable
- ifid_flush  out  1  zero IF/ID on next edge
- idex_flush  out  1  load bubble into ID/EX on next edge
- pipe_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB
- load_use_stall  out  1  load-use bubble this cycle
- bubble_cnt  out  CNT_W  saturating count of load-use bubble cycles
- freeze_cnt  out  CNT_W  saturating count of freeze cycles

## Operation
- Scoreboard: LOAD_LAT-1 registered entries {valid, rd}, sb[1..LOAD_LAT-1]. The virtual entry sb[0] is the combinational pair {idex_mem_read, idex_rd}. No registers are instantiated when LOAD_LAT=1.
- Advance happens on each edge with pipe_freeze=0: sb[1] takes sb[0], sb[k] takes sb[k-1]. When pipe_freeze=1 the scoreboard holds.
- Match: an entry is valid, its rd is not 0, and rd equals some source i with ifid_src_used[i]=1. Register 0 never matches.
- Priority, highest first, one action per cycle:
  - FREEZE (dmem_busy=1): pc_we=0, ifid_we=0, pipe_freeze=1, both flushes 0, load_use_stall=0. A pending branch_flush is deferred and stays asserted by EX.
  - FLUSH (branch_flush=1): pc_we=1, ifid_we=1, ifid_flush=1, idex_flush=1, load_use_stall=0. The ID instruction is killed, so no hazard is raised.
  - BUBBLE (any match): pc_we=0, ifid_we=0, idex_flush=1, pipe_freeze=0, load_use_stall=1.
  - RUN: pc_we=1, ifid_we=1, all others 0.
- Counters: bubble_cnt increments in BUBBLE and freeze_cnt increments in FREEZE. Both saturate at all-ones. cnt_clr wins over increment; the value is 0 after the edge.

## Timing
- All enable and flush outputs are combinational from the inputs and the scoreboard, effective at the next edge. Detection latency is 0 cycles.
- The counters and scoreboard are registered and update on the rising clk edge.
- A load followed immediately by a dependent instruction costs exactly LOAD_LAT bubbles; dependent distance d costs max(0, LOAD_LAT-d+1).
- While rst_n=0: scoreboard invalid, counters 0, pc_we=0, ifid_we=0, ifid_flush=1, idex_flush=1, pipe_freeze=0, load_use_stall=0.
- On reset deassertion the first edge behaves as RUN with an empty scoreboard.
- Reset mid-stall drops all pending bubbles.
- dmem_busy held N cycles gives exactly N freeze cycles, and scoreboard contents are unchanged across the freeze.
- Outputs are X-free for any ifid_src_used, including all zero, which yields no match.

## Structure
- The shared package holds the action encoding (RUN, BUBBLE, FLUSH, FREEZE) and the REG_ZERO constant. The package is used by the pipeline top and the benches.
- One sub-module, hazard_sat_counter (parameter CNT_W; ports inc, clr), is instantiated twice.

## Test plan
- LOAD_LAT=1, load to r5, then next instruction reads r5 on src1 → one cycle with pc_we=0, idex_flush=1, load_use_stall=1; bubble_cnt=1.
- LOAD_LAT=3, load r7, then a dependent at distance 1 and an independent at distance 2 → dependent stalls 3 cycles; a separate run with a dependent at distance 3 stalls 1 cycle.
- Load to r0, then a reader of r0 → no stall. Match on an operand with ifid_src_used=0 → no stall.
- dmem_busy for 4 cycles during a pending LOAD_LAT=2 hazard → 4 freeze cycles (freeze_cnt=4, no bubbles counted), then the remaining bubbles are issued.
- branch_flush and a hazard in the same cycle → ifid_flush=1, idex_flush=1, pc_we=1, bubble_cnt unchanged.
- rst_n pulsed low mid-bubble; counters preset near max with cnt_clr exercised → outputs take reset values immediately; counters saturate at 2^CNT_W-1 and read 0 after cnt_clr.
